// File: rtl/butter_seq_if.sv
// rtl/butter_seq_if.sv - control, sample stream, filter and result stream bundle for butter_seq
interface butter_seq_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 12
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic             filt_rst;
    logic             filt_en;
    logic [DW-1:0]    filt_data;
    logic [DW-1:0]    filt_out;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport master (
        output start, len, abort, in_data, in_valid, filt_out, out_ready,
        input  in_ready, filt_rst, filt_en, filt_data, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, len, abort, in_data, in_valid, filt_out, out_ready,
        output in_ready, filt_rst, filt_en, filt_data, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/butter_seq.sv
// rtl/butter_seq.sv - block sequencer feeding, flushing and draining the Butterworth low-pass filter
module butter_seq #(
    parameter int DW      = 16,
    parameter int LAT     = 4,
    parameter int CLR_CYC = 2,
    parameter int CNT_W   = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    butter_seq_if.slave bus
);
    localparam int CLR_W = $clog2(CLR_CYC) + 1;
    localparam int FL_W  = $clog2(LAT) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, smp_cnt, res_cnt;
    logic [CLR_W-1:0] clr_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic [LAT-1:0]   tag;
    logic             filt_en_q, cap_q, out_valid_q, done_q;
    logic [DW-1:0]    filt_data_q, out_data_q;

    logic busy, kill, slot_ok, en_ok, in_ready_c, acc, flush_go, issue;
    logic out_hs, capture, finish;

    always_comb begin
        busy       = (state != IDLE);
        kill       = busy && bus.abort;
        out_hs     = out_valid_q && bus.out_ready;
        slot_ok    = !out_valid_q || bus.out_ready;
        // One enable in flight at a time: its result must land in a free slot before the next issue.
        en_ok      = !filt_en_q && !cap_q && slot_ok && !kill;
        in_ready_c = (state == RUN) && en_ok && (smp_cnt != len_q);
        acc        = in_ready_c && bus.in_valid;
        flush_go   = (state == DRAIN) && en_ok && (flush_cnt != FL_W'(LAT));
        issue      = acc || flush_go;
        // After an enable the tag MSB marks whether the filter output belongs to a real sample.
        capture    = cap_q && tag[LAT-1];
        finish     = (state == WAIT) &&
                     ((res_cnt == len_q) || (out_hs && (res_cnt == len_q - CNT_W'(1))));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && (bus.len != '0)) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == CLR_W'(CLR_CYC - 1)) state_nxt = RUN;
            RUN:     if (acc && (smp_cnt == len_q - CNT_W'(1))) state_nxt = DRAIN;
            DRAIN:   if (flush_go && (flush_cnt == FL_W'(LAT - 1))) state_nxt = WAIT;
            WAIT:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            smp_cnt     <= '0;
            res_cnt     <= '0;
            clr_cnt     <= '0;
            flush_cnt   <= '0;
            tag         <= '0;
            filt_en_q   <= 1'b0;
            cap_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            filt_data_q <= '0;
            out_data_q  <= '0;
        end else begin
            done_q    <= !kill && (((state == IDLE) && bus.start && (bus.len == '0)) || finish);
            filt_en_q <= issue;
            cap_q     <= filt_en_q && !kill;

            if (acc)           filt_data_q <= bus.in_data;
            else if (flush_go) filt_data_q <= '0;

            if (kill) begin
                out_valid_q <= 1'b0;
                tag         <= '0;
            end else begin
                if (capture) begin
                    out_data_q  <= bus.filt_out;
                    out_valid_q <= 1'b1;
                end else if (out_hs) begin
                    out_valid_q <= 1'b0;
                end
                if (state == CLEAR) tag <= '0;
                else if (issue)     tag <= {tag[LAT-2:0], acc};
            end

            if ((state == IDLE) && bus.start) begin
                len_q   <= bus.len;
                clr_cnt <= '0;
            end

            if (state == CLEAR) begin
                clr_cnt   <= clr_cnt + 1'b1;
                smp_cnt   <= '0;
                flush_cnt <= '0;
                res_cnt   <= '0;
            end else begin
                if (acc)            smp_cnt   <= smp_cnt + 1'b1;
                if (flush_go)       flush_cnt <= flush_cnt + 1'b1;
                if (out_hs && busy) res_cnt   <= res_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.filt_rst  = (state == CLEAR);
    assign bus.filt_en   = filt_en_q;
    assign bus.filt_data = filt_data_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_butter_seq.sv
// tb/tb_butter_seq.sv - directed self-checking bench for butter_seq with a behavioural filter
module tb_butter_seq;
    localparam int DW    = 16;
    localparam int LAT   = 4;
    localparam int CNT_W = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    butter_seq_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    butter_seq #(.DW(DW), .LAT(LAT), .CLR_CYC(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Filter stand-in: LAT-stage delay line adding 3 on entry, advancing only on filt_en.
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
        if (bus.filt_rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else if (bus.filt_en) begin
            pipe[0] <= bus.filt_data + 16'h0003;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.filt_out = pipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int            rst_cyc, en_cnt, consec, acc_cnt, done_cnt, busy_cyc, fd_bad, stall_bad, stall_cyc;
    logic          prev_en;
    logic [DW-1:0] prev_fd;
    logic [DW-1:0] got [$];
    logic          mon_clr = 1'b0;
    logic          stall_on = 1'b0;
    logic [DW-1:0] src  [8];
    logic [DW-1:0] expv [8];
    logic [3:0]    vpat = 4'b1001;

    always @(negedge clk) begin
        if (mon_clr) begin
            rst_cyc = 0; en_cnt = 0; consec = 0; acc_cnt = 0; done_cnt = 0;
            busy_cyc = 0; fd_bad = 0; stall_bad = 0; stall_cyc = 0;
            got.delete();
        end else begin
            if (bus.filt_rst) rst_cyc++;
            if (bus.filt_en) en_cnt++;
            if (bus.filt_en && prev_en) consec++;
            if (bus.in_valid && bus.in_ready) acc_cnt++;
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            if (bus.done) done_cnt++;
            if (bus.busy) busy_cyc++;
            if ((bus.filt_data != prev_fd) && !bus.filt_en) fd_bad++;
            if (stall_on) begin
                stall_cyc++;
                if (bus.filt_en || bus.in_ready || !bus.out_valid || (bus.out_data != expv[0]))
                    stall_bad++;
            end
        end
        prev_en = bus.filt_en;
        prev_fd = bus.filt_data;
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic check_out(input string tag, input int n);
        chk({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            chk(tag, (i < got.size()) ? got[i] : 16'hDEAD, expv[i]);
    endtask

    task automatic run_block(input int n, input bit gap, input bit stall, input bit restart,
                             input int abort_at, input bit rst_drain);
        int idx = 0;
        int cyc = 0;
        int stall_left = 0;
        bit first = 1'b0;
        bit early = 1'b0;
        clear_mon();
        @(posedge clk); #1 bus.start = 1'b1; bus.len = CNT_W'(n);
        @(posedge clk); #1 bus.start = 1'b0;
        while (done_cnt == 0 && cyc < 400) begin
            if (abort_at >= 0 && idx == abort_at) begin
                bus.abort = 1'b1; bus.in_valid = 1'b0;
                @(posedge clk); #1 bus.abort = 1'b0;
                chk("abort_out_valid", bus.out_valid, 0);
                chk("abort_busy", bus.busy, 0);
                repeat (4) @(posedge clk);
                #1 chk("abort_no_done", done_cnt, 0);
                early = 1'b1;
                break;
            end
            if (rst_drain && idx == n) begin
                #2 rst_n = 1'b0;
                #1 chk("rst_ctl", {bus.busy, bus.filt_en, bus.filt_rst, bus.in_ready, bus.out_valid, bus.done}, 0);
                chk("rst_filt_data", bus.filt_data, 0);
                chk("rst_out_data", bus.out_data, 0);
                early = 1'b1;
                break;
            end
            bus.in_valid = (idx < n) && (!gap || vpat[cyc % 4]);
            bus.in_data  = src[(idx < n) ? idx : 0];
            if (stall && !first && bus.out_valid) begin
                first = 1'b1;
                stall_left = 10;
            end
            stall_on = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            bus.out_ready = !stall_on;
            bus.start = restart && (cyc == 3);
            bus.len   = (restart && cyc == 3) ? CNT_W'(7) : CNT_W'(n);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk);
            #1 cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        stall_on     = 1'b0;
        bus.out_ready = 1'b1;
        if (!early) chk("block_timeout", (done_cnt != 0), 1);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.abort = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 chk("reset_ctl", {bus.busy, bus.filt_en, bus.filt_rst, bus.in_ready, bus.out_valid, bus.done}, 0);
        chk("reset_data", {bus.filt_data, bus.out_data}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Basic block, always ready.
        src[0] = 16'h0200; src[1] = 16'h0400; src[2] = 16'h0600; src[3] = 16'h0800;
        expv[0] = 16'h0203; expv[1] = 16'h0403; expv[2] = 16'h0603; expv[3] = 16'h0803;
        run_block(4, 0, 0, 0, -1, 0);
        chk("t1_filt_rst_cycles", rst_cyc, 2);
        chk("t1_enables", en_cnt, 8);
        chk("t1_accepts", acc_cnt, 4);
        chk("t1_consec_en", consec, 0);
        chk("t1_fd_hold", fd_bad, 0);
        check_out("t1_out", 4);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_busy_after", bus.busy, 0);

        // Downstream stall of 10 cycles on the first result.
        run_block(4, 0, 1, 0, -1, 0);
        chk("t2_stall_cycles", stall_cyc, 10);
        chk("t2_stall_hold", stall_bad, 0);
        chk("t2_consec_en", consec, 0);
        check_out("t2_out", 4);
        chk("t2_done_pulses", done_cnt, 1);

        // Zero-length block.
        clear_mon();
        @(posedge clk); #1 bus.start = 1'b1; bus.len = '0;
        @(posedge clk); #1 bus.start = 1'b0;
        chk("t3_done_pulse", bus.done, 1);
        @(posedge clk);
        #1 chk("t3_done_low", bus.done, 0);
        repeat (3) @(posedge clk);
        #1 chk("t3_done_count", done_cnt, 1);
        chk("t3_busy", busy_cyc, 0);
        chk("t3_filt_rst", rst_cyc, 0);
        chk("t3_filt_en", en_cnt, 0);

        // Abort after two accepts, then a clean LEN=2 block.
        run_block(4, 0, 0, 0, 2, 0);
        src[0] = 16'h0100; src[1] = 16'h0300;
        expv[0] = 16'h0103; expv[1] = 16'h0303;
        run_block(2, 0, 0, 0, -1, 0);
        chk("t4_filt_rst_cycles", rst_cyc, 2);
        check_out("t4_out", 2);
        chk("t4_done_pulses", done_cnt, 1);

        // Asynchronous reset in DRAIN, then LEN=1.
        src[0] = 16'h0200; src[1] = 16'h0400; src[2] = 16'h0600; src[3] = 16'h0800;
        run_block(4, 0, 0, 0, -1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        src[0] = 16'h0AB0; expv[0] = 16'h0AB3;
        run_block(1, 0, 0, 0, -1, 0);
        check_out("t5_out", 1);
        chk("t5_enables", en_cnt, 5);
        chk("t5_done_pulses", done_cnt, 1);

        // Gappy input with an ignored START mid-block.
        src[0] = 16'h0111; src[1] = 16'h0222; src[2] = 16'h0333;
        expv[0] = 16'h0114; expv[1] = 16'h0225; expv[2] = 16'h0336;
        run_block(3, 1, 0, 1, -1, 0);
        chk("t6_accepts", acc_cnt, 3);
        chk("t6_enables", en_cnt, 7);
        chk("t6_consec_en", consec, 0);
        chk("t6_fd_hold", fd_bad, 0);
        check_out("t6_out", 3);
        chk("t6_done_pulses", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
